freq_avg: RTL and testbench
===========================

# freq_avg

Averaging and result-delivery stage directly downstream of the gated edge counter in the frequency-counter path. It watches the counter's delayed gate (`enable_sync_d2`) and captures the 10-bit `cnt` once per closed measurement window. After 2^AVG_LOG2 windows it presents the mean count on a valid/ready result port. Single clock domain, the same `clk` that drives the counter.

## Interface
- `AVG_LOG2`, 2: log2 of windows averaged per result; legal 0..4 (0 = pass-through of each window).
- `LO_LIMIT`, 10'd100: lower in-range bound, inclusive; used only with `FREQ_AVG_RANGE_EN`.
- `HI_LIMIT`, 10'd900: upper in-range bound, inclusive; used only with `FREQ_AVG_RANGE_EN`.
- `clk`  in  1  counter clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable_sync_d2`  in  1  delayed synchronized gate, same net the counter uses.
- `cnt`  in  10  counter result; stable while `enable_sync_d2` is low.
- `clear`  in  1  synchronous restart of averaging and flags.
- `res_ready`  in  1  consumer accepts `res_data`.
- `res_valid`  out  1  `res_data` holds an unconsumed average.
- `res_data`  out  10  averaged count.
- `res_overrun`  out  1  sticky: a completed average was dropped.
- `res_oor`  out  1  the current `res_data` is outside [LO_LIMIT, HI_LIMIT].

## Operation
- `d2_q` registers `enable_sync_d2`. A fall event is `d2_q==1 && enable_sync_d2==0`.
- FSM states:
  - WAIT_FALL: on a fall event, go to SETTLE.
  - SETTLE: one cycle, so the counter's `cnt` load completes. `acc += cnt`, `idx += 1`. If `idx == 2^AVG_LOG2-1`, go to PUBLISH; otherwise go to WAIT_FALL.
  - PUBLISH: one cycle. Compute the average, attempt to load the output, zero `acc` and `idx`, and return to WAIT_FALL.
- Arithmetic:
  - `acc` is 10+AVG_LOG2 bits wide and can never overflow.
  - Average = `acc[9+AVG_LOG2:AVG_LOG2]`, a truncating shift with no rounding.
- Output load in PUBLISH:
  - If `!res_valid`, or `res_valid && res_ready` in the same cycle: load `res_data`, set `res_valid=1`.
  - Otherwise, keep the old `res_data` and set `res_overrun=1`.
- Handshake: `res_valid` drops on the edge where `res_valid && res_ready`, unless a load occurs on that same edge. `res_data` is held while `res_valid` is high.
- A fall event arriving in SETTLE or PUBLISH is ignored. Windows are far longer than 2 cycles, so none is lost in normal use.
- `clear` has priority over all other actions. It forces WAIT_FALL and zeroes `acc`, `idx`, `res_valid`, `res_overrun` and `res_oor`. `res_data` is held. `d2_q` still tracks its input.

## Timing
- Reset values: `res_valid=0`, `res_data=0`, `res_overrun=0`, `res_oor=0`, FSM in WAIT_FALL, `acc=0`, `idx=0`, `d2_q=0`.
  - `d2_q` resets to 0, so a gate that is already low at reset release produces no spurious fall event.
- Edge sequence for the last window of a group:
  - E0: the fall event is seen.
  - E1: SETTLE adds `cnt`.
  - E2: PUBLISH loads the output.
  - `res_valid` is high from E2. Latency from the fall event to `res_valid` is 2 cycles.
- Reset asserted mid-operation discards the partial accumulation immediately (asynchronous). Operation restarts at the first fall event after release.
- `res_overrun` stays high until `clear` or reset.

## Configuration
- `FREQ_AVG_RANGE_EN` defined:
  - `res_oor` is registered alongside every `res_data` load.
  - `res_oor = (avg < LO_LIMIT) || (avg > HI_LIMIT)`.
  - `res_oor` holds with `res_data` and is cleared by `clear`.
- `FREQ_AVG_RANGE_EN` undefined: `res_oor` is tied to 0 and no comparators are built. `LO_LIMIT` and `HI_LIMIT` are ignored.

## Test plan
- AVG_LOG2=2, `res_ready=1`, four windows with `cnt` = 400, 401, 402, 403:
  - `res_valid` pulses once, 2 cycles after the 4th fall event.
  - `res_data` = 401 (1606>>2, truncated).
- AVG_LOG2=0, single window with `cnt`=1023 -> `res_data`=1023 and `res_valid` 2 cycles after the fall event. No overflow.
- `res_ready=0` held across two complete groups (averages 200, then 300):
  - `res_data` stays 200.
  - `res_overrun`=1 after the second PUBLISH.
  - Asserting `res_ready` then drops `res_valid`; `res_overrun` stays 1.
- `res_ready=1` exactly in the PUBLISH cycle of the next result -> old result consumed, new result loaded, `res_valid` stays 1 with no gap.
- Reset or `clear` after 2 of 4 windows, then 4 windows of 500 -> `res_data`=500. The earlier partial sums do not contribute.
- With `FREQ_AVG_RANGE_EN`, defaults LO_LIMIT=100 and HI_LIMIT=900, windows of 99, 100, 900 and 901 (AVG_LOG2=0) -> `res_oor` = 1, 0, 0, 1. Without the macro, `res_oor` stays 0.

Source files
------------

// File: rtl/freq_avg.sv
// Averages the gated counter result over 2**AVG_LOG2 windows and presents it on a valid/ready port.
// Optional range flag built only when FREQ_AVG_RANGE_EN is defined.
module freq_avg #(
  parameter int unsigned AVG_LOG2 = 2,
  parameter logic [9:0]  LO_LIMIT = 10'd100,
  parameter logic [9:0]  HI_LIMIT = 10'd900
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_sync_d2,
  input  logic [9:0] cnt,
  input  logic       clear,
  input  logic       res_ready,
  output logic       res_valid,
  output logic [9:0] res_data,
  output logic       res_overrun,
  output logic       res_oor
);

  localparam int unsigned AW       = 10 + AVG_LOG2;
  localparam logic [4:0]  IDX_LAST = 5'((1 << AVG_LOG2) - 1);

  localparam logic [1:0] S_WAIT_FALL = 2'd0;
  localparam logic [1:0] S_SETTLE    = 2'd1;
  localparam logic [1:0] S_PUBLISH   = 2'd2;

  if (AVG_LOG2 > 4 || LO_LIMIT > HI_LIMIT) begin : g_bad_cfg
    $error("freq_avg: AVG_LOG2 must be 0..4 and LO_LIMIT <= HI_LIMIT");
  end

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [4:0]    idx_q, idx_d;
  logic          d2_q;
  logic          valid_q, valid_d;
  logic [9:0]    data_q, data_d;
  logic          ovr_q, ovr_d;
  logic          fall;
  logic          load;
  logic [9:0]    avg;

  assign fall = d2_q & ~enable_sync_d2;
  assign avg  = acc_q[AW-1:AVG_LOG2];
  // A slot is free if empty or being consumed on this very edge.
  assign load = (state_q == S_PUBLISH) && (!valid_q || res_ready);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = ovr_q;

    if (valid_q && res_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_WAIT_FALL: begin
        if (fall) begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        acc_d   = acc_q + AW'(cnt);
        idx_d   = idx_q + 5'd1;
        state_d = (idx_q == IDX_LAST) ? S_PUBLISH : S_WAIT_FALL;
      end
      S_PUBLISH: begin
        acc_d   = '0;
        idx_d   = '0;
        state_d = S_WAIT_FALL;
        if (load) begin
          data_d  = avg;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = S_WAIT_FALL;
      end
    endcase

    if (clear) begin
      state_d = S_WAIT_FALL;
      acc_d   = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT_FALL;
      acc_q   <= '0;
      idx_q   <= '0;
      d2_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      d2_q    <= enable_sync_d2;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef FREQ_AVG_RANGE_EN
  logic oor_q;

  // Flag travels with the data word so it always describes the value on res_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_q <= 1'b0;
    end else if (clear) begin
      oor_q <= 1'b0;
    end else if (load) begin
      oor_q <= (avg < LO_LIMIT) || (avg > HI_LIMIT);
    end
  end

  assign res_oor = oor_q;
`else
  assign res_oor = 1'b0;
`endif

  assign res_valid   = valid_q;
  assign res_data    = data_q;
  assign res_overrun = ovr_q;

endmodule

// File: tb/tb_freq_avg.sv
// Self-checking bench for freq_avg: an averaging instance (AVG_LOG2=2) and a pass-through instance (AVG_LOG2=0).
module tb_freq_avg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, clr, rdy;
  logic [9:0] cnt;
  logic       vld;
  logic [9:0] dat;
  logic       ovr, oor;
  logic       en0, clr0, rdy0;
  logic [9:0] cnt0;
  logic       vld0;
  logic [9:0] dat0;
  logic       ovr0, oor0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  freq_avg #(.AVG_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable_sync_d2(en), .cnt(cnt), .clear(clr),
    .res_ready(rdy), .res_valid(vld), .res_data(dat), .res_overrun(ovr), .res_oor(oor)
  );

  freq_avg #(.AVG_LOG2(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable_sync_d2(en0), .cnt(cnt0), .clear(clr0),
    .res_ready(rdy0), .res_valid(vld0), .res_data(dat0), .res_overrun(ovr0), .res_oor(oor0)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Open a gate, then drop it with the final count; the next edge is the fall event.
  task automatic win_fall(input bit which, input logic [9:0] c);
    if (which) en0 = 1'b1; else en = 1'b1;
    repeat (3) tick();
    if (which) begin cnt0 = c; en0 = 1'b0; end
    else begin cnt = c; en = 1'b0; end
  endtask

  task automatic window(input bit which, input logic [9:0] c);
    win_fall(which, c);
    repeat (4) tick();
  endtask

  // Ends right after the PUBLISH edge (E2) of the group's final window.
  task automatic last_window(input bit which, input logic [9:0] c);
    win_fall(which, c);
    repeat (3) tick();
  endtask

  function automatic logic exp_oor(input logic [9:0] v);
`ifdef FREQ_AVG_RANGE_EN
    return (v < 10'd100) || (v > 10'd900);
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    en = 0; clr = 0; rdy = 0; cnt = 0;
    en0 = 0; clr0 = 0; rdy0 = 0; cnt0 = 0;
    repeat (3) tick();
    total += 8;
    if (vld !== 1'b0)   begin bad++; $display("FAIL reset_valid: got %b want 0", vld); end
    if (dat !== 10'd0)  begin bad++; $display("FAIL reset_data: got %0d want 0", dat); end
    if (ovr !== 1'b0)   begin bad++; $display("FAIL reset_overrun: got %b want 0", ovr); end
    if (oor !== 1'b0)   begin bad++; $display("FAIL reset_oor: got %b want 0", oor); end
    if (vld0 !== 1'b0)  begin bad++; $display("FAIL reset_valid0: got %b want 0", vld0); end
    if (dat0 !== 10'd0) begin bad++; $display("FAIL reset_data0: got %0d want 0", dat0); end
    if (ovr0 !== 1'b0)  begin bad++; $display("FAIL reset_overrun0: got %b want 0", ovr0); end
    if (oor0 !== 1'b0)  begin bad++; $display("FAIL reset_oor0: got %b want 0", oor0); end
    rst_n = 1'b1;
    repeat (2) tick();
    total++;
    if (vld !== 1'b0) begin bad++; $display("FAIL release_valid: got %b want 0", vld); end
  endtask

  task automatic test_average();
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      window(0, 10'(400 + i));
      total++;
      if (vld !== 1'b0) begin bad++; $display("FAIL avg_early_valid win %0d: got %b want 0", i, vld); end
    end
    win_fall(0, 10'd403);
    tick();
    total++;
    if (vld !== 1'b0) begin bad++; $display("FAIL avg_lat_e0: got %b want 0", vld); end
    tick();
    total++;
    if (vld !== 1'b0) begin bad++; $display("FAIL avg_lat_e1: got %b want 0", vld); end
    tick();
    total += 2;
    if (vld !== 1'b1)  begin bad++; $display("FAIL avg_lat_e2: got %b want 1", vld); end
    if (dat !== 10'd401) begin bad++; $display("FAIL avg_data: got %0d want 401", dat); end
    $display("result avg data=%0d", dat);
    tick();
    total++;
    if (vld !== 1'b0) begin bad++; $display("FAIL avg_pulse_drop: got %b want 0", vld); end
    tick();
  endtask

  task automatic test_passthrough();
    rdy0 = 1'b1;
    win_fall(1, 10'd1023);
    tick();
    tick();
    total++;
    if (vld0 !== 1'b0) begin bad++; $display("FAIL pass_lat_e1: got %b want 0", vld0); end
    tick();
    total += 3;
    if (vld0 !== 1'b1)     begin bad++; $display("FAIL pass_valid: got %b want 1", vld0); end
    if (dat0 !== 10'd1023) begin bad++; $display("FAIL pass_data: got %0d want 1023", dat0); end
    if (ovr0 !== 1'b0)     begin bad++; $display("FAIL pass_overrun: got %b want 0", ovr0); end
    $display("result pass data=%0d", dat0);
    repeat (2) tick();
  endtask

  task automatic test_overrun();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) window(0, 10'd200);
    last_window(0, 10'd200);
    total += 3;
    if (vld !== 1'b1)    begin bad++; $display("FAIL ovr_first_valid: got %b want 1", vld); end
    if (dat !== 10'd200) begin bad++; $display("FAIL ovr_first_data: got %0d want 200", dat); end
    if (ovr !== 1'b0)    begin bad++; $display("FAIL ovr_first_flag: got %b want 0", ovr); end
    repeat (2) tick();
    for (int i = 0; i < 3; i++) window(0, 10'd300);
    last_window(0, 10'd300);
    total += 3;
    if (vld !== 1'b1)    begin bad++; $display("FAIL ovr_second_valid: got %b want 1", vld); end
    if (dat !== 10'd200) begin bad++; $display("FAIL ovr_held_data: got %0d want 200", dat); end
    if (ovr !== 1'b1)    begin bad++; $display("FAIL ovr_flag: got %b want 1", ovr); end
    $display("result overrun data=%0d overrun=%b", dat, ovr);
    rdy = 1'b1;
    tick();
    total += 2;
    if (vld !== 1'b0) begin bad++; $display("FAIL ovr_drain_valid: got %b want 0", vld); end
    if (ovr !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", ovr); end
    rdy = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total += 3;
    if (ovr !== 1'b0)    begin bad++; $display("FAIL clr_overrun: got %b want 0", ovr); end
    if (vld !== 1'b0)    begin bad++; $display("FAIL clr_valid: got %b want 0", vld); end
    if (dat !== 10'd200) begin bad++; $display("FAIL clr_data_hold: got %0d want 200", dat); end
    for (int i = 0; i < 3; i++) window(0, 10'd600);
    last_window(0, 10'd600);
    tick();
    for (int i = 0; i < 3; i++) window(0, 10'd700);
    win_fall(0, 10'd700);
    tick();
    tick();
    total += 2;
    if (vld !== 1'b1)    begin bad++; $display("FAIL b2b_pre_valid: got %b want 1", vld); end
    if (dat !== 10'd600) begin bad++; $display("FAIL b2b_pre_data: got %0d want 600", dat); end
    rdy = 1'b1;
    tick();
    total += 3;
    if (vld !== 1'b1)    begin bad++; $display("FAIL b2b_valid: got %b want 1", vld); end
    if (dat !== 10'd700) begin bad++; $display("FAIL b2b_data: got %0d want 700", dat); end
    if (ovr !== 1'b0)    begin bad++; $display("FAIL b2b_overrun: got %b want 0", ovr); end
    $display("result b2b data=%0d", dat);
    tick();
    total++;
    if (vld !== 1'b0) begin bad++; $display("FAIL b2b_drop: got %b want 0", vld); end
  endtask

  task automatic test_partial_restart();
    rdy = 1'b1;
    window(0, 10'd50);
    window(0, 10'd50);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) window(0, 10'd500);
    last_window(0, 10'd500);
    total += 2;
    if (vld !== 1'b1)    begin bad++; $display("FAIL clr_restart_valid: got %b want 1", vld); end
    if (dat !== 10'd500) begin bad++; $display("FAIL clr_restart_data: got %0d want 500", dat); end
    repeat (2) tick();
    window(0, 10'd77);
    window(0, 10'd77);
    en = 1'b1;
    tick();
    #3 rst_n = 1'b0;
    #1;
    total += 2;
    if (dat !== 10'd0) begin bad++; $display("FAIL async_reset_data: got %0d want 0", dat); end
    if (vld !== 1'b0)  begin bad++; $display("FAIL async_reset_valid: got %b want 0", vld); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) window(0, 10'd500);
    last_window(0, 10'd500);
    total += 2;
    if (vld !== 1'b1)    begin bad++; $display("FAIL rst_restart_valid: got %b want 1", vld); end
    if (dat !== 10'd500) begin bad++; $display("FAIL rst_restart_data: got %0d want 500", dat); end
    repeat (2) tick();
  endtask

  task automatic test_range();
    logic [9:0] vals [4];
    vals[0] = 10'd99; vals[1] = 10'd100; vals[2] = 10'd900; vals[3] = 10'd901;
    rdy0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      last_window(1, vals[i]);
      total += 2;
      if (dat0 !== vals[i]) begin bad++; $display("FAIL range_data %0d: got %0d want %0d", i, dat0, vals[i]); end
      if (oor0 !== exp_oor(vals[i])) begin
        bad++; $display("FAIL range_oor %0d: got %b want %b", i, oor0, exp_oor(vals[i]));
      end
      $display("result range data=%0d oor=%b", dat0, oor0);
      repeat (2) tick();
    end
  endtask

  task automatic test_random();
    logic [9:0] c;
    int         sum;
    logic [9:0] expv;
    bit         found;
    rdy = 1'b1;
    for (int g = 0; g < 12; g++) begin
      sum = 0;
      for (int w = 0; w < 3; w++) begin
        c = 10'($urandom_range(0, 1023));
        sum += int'(c);
        window(0, c);
      end
      c = 10'($urandom_range(0, 1023));
      sum += int'(c);
      expv = 10'(sum / 4);
      win_fall(0, c);
      found = 1'b0;
      for (int k = 0; k < 6 && !found; k++) begin
        tick();
        if (vld === 1'b1) found = 1'b1;
      end
      total++;
      if (!found) begin
        bad++; $display("FAIL rand_timeout group %0d: valid never rose, want data %0d", g, expv);
      end else if (dat !== expv || oor !== exp_oor(expv)) begin
        bad++; $display("FAIL rand_data group %0d: got %0d/%b want %0d/%b", g, dat, oor, expv, exp_oor(expv));
      end
      $display("result rand group=%0d data=%0d expect=%0d", g, dat, expv);
      repeat (2) tick();
    end
  endtask

  initial begin
    test_reset();
    test_average();
    test_passthrough();
    test_overrun();
    test_back_to_back();
    test_partial_restart();
    test_range();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
